// File: rtl/regfile_param_if.sv
// Bus between writeback/decode and the parametrised register file.
// Carries the write port, both read ports and the clear-engine status.
interface regfile_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   ra1;
  logic [XLEN-1:0] rd1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd2;
  logic [AW-1:0]   clr_idx;

  modport master (
    output we, waddr, wdata, ra1, ra2,
    input  ready, rd1, rd2, clr_idx
  );

  modport slave (
    input  we, waddr, wdata, ra1, ra2,
    output ready, rd1, rd2, clr_idx
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a sequential clear engine
// that zeroes one register per cycle after reset before accepting writes.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] regs [NREGS];
  logic            clr_last;
  logic            wr_zero;
  logic            write_ok;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  assign clr_last = (clr_idx == LAST_IDX);
  assign wr_zero  = (ZERO_REG != 0) && (bus.waddr == '0);
  assign write_ok = (state == RUN) && bus.we && !wr_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_last) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = CLEAR;
    endcase
  end

  // The pointer wraps to 0 on the last clear so it reads 0 throughout RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_last ? '0 : clr_idx + AW'(1);
    end
  end

  // Storage has no reset; the clear engine owns it until RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (write_ok) begin
        regs[bus.waddr] <= bus.wdata;
      end
    end
  end

  // Zero-register override wins over the bypass path.
  function automatic logic [XLEN-1:0] read_port(
    input logic [AW-1:0]   addr,
    input logic            running,
    input logic            wr_ok,
    input logic [AW-1:0]   wr_addr,
    input logic [XLEN-1:0] wr_data,
    input logic [XLEN-1:0] stored
  );
    logic [XLEN-1:0] data;
    data = stored;
    if (!running) begin
      data = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end else if ((BYPASS != 0) && wr_ok && (wr_addr == addr)) begin
      data = wr_data;
    end
    return data;
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    rd1 = read_port(bus.ra1, state == RUN, write_ok, bus.waddr, bus.wdata,
                    regs[bus.ra1]);
    rd2 = read_port(bus.ra2, state == RUN, write_ok, bus.waddr, bus.wdata,
                    regs[bus.ra2]);
  end

  assign bus.rd1     = rd1;
  assign bus.rd2     = rd2;
  assign bus.ready   = (state == RUN);
  assign bus.clr_idx = clr_idx;
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: a bypassing instance and a BYPASS=0
// instance share the same stimulus; expectations are queued and checked at negedge.
module tb_regfile_param;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic clk;
  logic rst;
  logic probe;
  int   checks;
  int   failures;

  regfile_param_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
  regfile_param_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_nb ();

  assign bus_nb.we    = bus.we;
  assign bus_nb.waddr = bus.waddr;
  assign bus_nb.wdata = bus.wdata;
  assign bus_nb.ra1   = bus.ra1;
  assign bus_nb.ra2   = bus.ra2;

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_param #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus_nb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_data;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_nb1;
    bit          chk_stat;
    logic        e_ready;
    logic [4:0]  e_clr;
  } exp_t;

  exp_t sb[$];

  task automatic compare(input string name, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s got=%h expected=%h", name, what, act, exp);
    end
  endtask

  // Monitor: consumes one expectation per probed cycle, independent of stimulus.
  always @(negedge clk) begin
    if (probe) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty got=0 expected=1");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) begin
          compare(e.name, "rd1", bus.rd1, e.e_rd1);
          compare(e.name, "rd2", bus.rd2, e.e_rd2);
          compare(e.name, "nb_rd1", bus_nb.rd1, e.e_nb1);
        end
        if (e.chk_stat) begin
          compare(e.name, "ready", {31'd0, bus.ready}, {31'd0, e.e_ready});
          compare(e.name, "clr_idx", {27'd0, bus.clr_idx}, {27'd0, e.e_clr});
          compare(e.name, "nb_ready", {31'd0, bus_nb.ready}, {31'd0, e.e_ready});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] waddr,
                               input logic [31:0] wdata,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    bus.we    = we;
    bus.waddr = waddr;
    bus.wdata = wdata;
    bus.ra1   = ra1;
    bus.ra2   = ra2;
  endtask

  task automatic checkOutput(input string name, input bit chk_data,
                             input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                             input logic [31:0] e_nb1, input bit chk_stat,
                             input logic e_ready, input logic [4:0] e_clr);
    exp_t e;
    e.name     = name;
    e.chk_data = chk_data;
    e.e_rd1    = e_rd1;
    e.e_rd2    = e_rd2;
    e.e_nb1    = e_nb1;
    e.chk_stat = chk_stat;
    e.e_ready  = e_ready;
    e.e_clr    = e_clr;
    sb.push_back(e);
    probe = 1'b1;
  endtask

  // One rst edge, then the clear sequence with writes to reg 3 held active.
  // abort_at>0 returns after that many clear edges with the check still pending.
  task automatic runClear(input int abort_at, input logic [4:0] ra);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h12345678, ra, 5'd3);
    step();
    rst = 1'b0;
    checkOutput("reset_state", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    for (int k = 1; k <= NREGS; k++) begin
      if (k == NREGS) begin
        applyStimulus(1'b0, 5'd0, 32'h0, ra, 5'd3);
        checkOutput("clear_done", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0);
      end else begin
        checkOutput("clearing", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'(k));
      end
      if (k == abort_at) return;
      step();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    probe    = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    // Reset, full clear with writes to reg 3 ignored, then every address reads 0.
    runClear(0, 5'd3);
    for (int i = 0; i < NREGS; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'(i), 5'(NREGS - 1 - i));
      checkOutput("read_all_zero", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0);
      step();
    end

    // Basic write/read; bypass instance forwards, non-bypass shows the old value.
    applyStimulus(1'b1, 5'd9, 32'h00000020, 5'd9, 5'd6);
    checkOutput("wr9_same_cycle", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd6);
    checkOutput("rd9_next_cycle", 1'b1, 32'h20, 32'h0, 32'h20, 1'b1, 1'b1, 5'd0);
    step();

    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    checkOutput("bypass5", 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("rd5_after", 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                1'b0, 1'b1, 5'd0);
    step();

    // Zero register: write dropped and bypass suppressed.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd9);
    checkOutput("zero_same_cycle", 1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b1, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
    checkOutput("zero_after", 1'b1, 32'h0, 32'h20, 32'h0, 1'b0, 1'b1, 5'd0);
    step();

    applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd5);
    checkOutput("overwrite9", 1'b1, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h20,
                1'b0, 1'b1, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("overwrite9_after", 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                1'b0, 1'b1, 5'd0);
    step();

    // Reset mid-clear at clr_idx=10, then a complete 32-edge clear.
    runClear(10, 5'd9);
    runClear(0, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    checkOutput("post_midclear", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0);
    step();

    // Reset during RUN wipes a freshly written register.
    applyStimulus(1'b1, 5'd9, 32'h00000055, 5'd9, 5'd0);
    checkOutput("wr9_run", 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("rd9_run", 1'b1, 32'h55, 32'h55, 32'h55, 1'b1, 1'b1, 5'd0);
    step();
    runClear(0, 5'd9);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("rd9_after_run_reset", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 5'd0);
    step();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
